// File: rtl/icache_refill_ctrl.sv
// Purpose : hit check and single-line refill controller for an 8-line direct-mapped I-cache.
// Latency : hit returns instr in the same cycle; a miss with back-to-back acks resolves in 6 cycles.
// Backpr. : stall holds fetch during refill; the memory port waits indefinitely on mem_ack.
// Ports   : fetch side (fetch_req, pc -> instr, instr_valid, stall),
//           storage side (cache_idx, cache_valid/tag_rd/data_rd in; cache_hit, cache_tag, cache_data out),
//           memory side (mem_req, mem_addr -> mem_rdata, mem_ack), miss_count statistic.
module icache_refill_ctrl #(
  parameter int TAG_W = 27,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_req,
  input  logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             stall,
  output logic [IDX_W-1:0] cache_idx,
  input  logic             cache_valid,
  input  logic [TAG_W-1:0] cache_tag_rd,
  input  logic [127:0]     cache_data_rd,
  output logic             cache_hit,
  output logic [TAG_W-1:0] cache_tag,
  output logic [127:0]     cache_data,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [1:0] ST_LOOKUP = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [1:0]       k_q, k_d;
  logic [127:0]     buf_q, buf_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] pc_idx;
  logic [1:0]       pc_word;
  logic             lookup_hit;

  assign pc_tag  = pc[31 -: TAG_W];
  assign pc_idx  = pc[2 +: IDX_W];
  assign pc_word = pc[1:0];

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    k_d          = k_q;
    buf_d        = buf_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    miss_count_d = miss_count_q;

    cache_idx   = pc_idx;
    instr_valid = 1'b0;
    stall       = 1'b0;
    cache_hit   = 1'b1;
    // Storage read port is indexed by cache_idx, so this is only meaningful in LOOKUP.
    lookup_hit  = cache_valid && (cache_tag_rd == pc_tag);
    instr       = cache_data_rd[{pc_word, 5'd0} +: 32];

    case (state_q)
      ST_LOOKUP: begin
        if (fetch_req) begin
          if (lookup_hit) begin
            instr_valid = 1'b1;
          end else begin
            stall      = 1'b1;
            miss_tag_d = pc_tag;
            miss_idx_d = pc_idx;
            k_d        = 2'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_tag, pc_idx, 2'b00};
            if (miss_count_q != '1) begin
              miss_count_d = miss_count_q + 1'b1;
            end
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        cache_idx = miss_idx_q;
        stall     = 1'b1;
        if (mem_req_q && mem_ack) begin
          buf_d[{k_q, 5'd0} +: 32] = mem_rdata;
          k_d        = k_q + 2'd1;
          mem_addr_d = {miss_tag_q, miss_idx_q, k_q + 2'd1};
          if (k_q == 2'd3) begin
            mem_req_d = 1'b0;
            state_d   = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        cache_idx = miss_idx_q;
        stall     = 1'b1;
        cache_hit = 1'b0;
        state_d   = ST_LOOKUP;
      end
      default: state_d = ST_LOOKUP;
    endcase

    // While reset is held the storage must never see a write strobe and fetch is released.
    if (!rst_n) begin
      stall     = 1'b0;
      cache_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOOKUP;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      k_q          <= '0;
      buf_q        <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      k_q          <= k_d;
      buf_q        <= buf_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign cache_tag  = miss_tag_q;
  assign cache_data = buf_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Purpose : bench for icache_refill_ctrl with a storage array, a memory responder and a line-level model.
// Latency : model predicts every output cycle by cycle from pending-line bookkeeping.
// Ports   : none; drives the DUT at posedge+1 and samples it at negedge.
`timescale 1ns/1ps
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fetch_req = 1'b0;
  logic [31:0]  pc = 32'h0;
  logic [31:0]  instr;
  logic         instr_valid, stall;
  logic [2:0]   cache_idx;
  logic         cache_valid;
  logic [26:0]  cache_tag_rd;
  logic [127:0] cache_data_rd;
  logic         cache_hit;
  logic [26:0]  cache_tag;
  logic [127:0] cache_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_rdata = 32'h0;
  logic         mem_ack = 1'b0;
  logic [15:0]  miss_count;

  icache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .cache_idx(cache_idx), .cache_valid(cache_valid), .cache_tag_rd(cache_tag_rd),
    .cache_data_rd(cache_data_rd), .cache_hit(cache_hit), .cache_tag(cache_tag),
    .cache_data(cache_data), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Physical storage array: written whenever the write-inhibit drops.
  logic         st_v [8];
  logic [26:0]  st_t [8];
  logic [127:0] st_d [8];
  assign cache_valid   = st_v[cache_idx];
  assign cache_tag_rd  = st_t[cache_idx];
  assign cache_data_rd = st_d[cache_idx];
  always @(posedge clk) begin
    if (!cache_hit) begin
      st_v[cache_idx] <= 1'b1;
      st_t[cache_idx] <= cache_tag;
      st_d[cache_idx] <= cache_data;
    end
  end

  // Memory responder: ack after ack_delay idle cycles; optional ack with no request outstanding.
  int ack_delay = 0;
  bit spurious = 1'b0;
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack   = spurious;
        mem_rdata = 32'hDEAD_BEEF;
        wait_cnt  = 0;
      end
    end
  end

  // Event logs for the directed literal checks.
  logic [31:0]  ack_log [$];
  logic [26:0]  wr_tag_log [$];
  logic [2:0]   wr_idx_log [$];
  logic [127:0] last_wr_data;
  int           last_wr_cyc = -1;
  int           req_cycles = 0;

  // Model: expected storage contents as words, plus the line currently being gathered.
  bit          e_v [8];
  logic [26:0] e_t [8];
  logic [31:0] e_w [8][4];
  bit          m_known = 1'b0;
  bit          m_busy = 1'b0;
  int          m_words = 0;
  logic [31:0] m_line [4];
  logic [26:0] m_tag = '0;
  logic [2:0]  m_idx = '0;
  int          m_cnt = 0;

  initial begin : monitor
    logic [26:0] pt;
    logic [2:0]  pi;
    logic [1:0]  pw;
    logic [1:0]  wsel;
    bit          hit;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ack) ack_log.push_back(mem_addr);
      if (!cache_hit) begin
        wr_tag_log.push_back(cache_tag);
        wr_idx_log.push_back(cache_idx);
        last_wr_data = cache_data;
        last_wr_cyc  = cyc;
      end
      if (mem_req) req_cycles++;

      if (!rst_n) begin
        if (m_known) begin
          chk("rst_stall", stall, 1'b0);
          chk("rst_cache_hit", cache_hit, 1'b1);
          chk("rst_mem_req", mem_req, m_busy && (m_words < 4));
          chk("rst_miss_count", miss_count, m_cnt);
        end
        m_known = 1'b1;
        m_busy  = 1'b0;
        m_words = 0;
        m_cnt   = 0;
      end else if (m_known) begin
        chk("miss_count", miss_count, m_cnt);
        if (!m_busy) begin
          pt  = pc[31:5];
          pi  = pc[4:2];
          pw  = pc[1:0];
          hit = e_v[pi] && (e_t[pi] == pt);
          chk("lk_cache_idx", cache_idx, pi);
          chk("lk_cache_hit", cache_hit, 1'b1);
          chk("lk_mem_req", mem_req, 1'b0);
          chk("lk_instr_valid", instr_valid, fetch_req && hit);
          chk("lk_stall", stall, fetch_req && !hit);
          if (fetch_req && hit) chk("lk_instr", instr, e_w[pi][pw]);
          if (fetch_req && !hit) begin
            m_busy  = 1'b1;
            m_words = 0;
            m_tag   = pt;
            m_idx   = pi;
            if (m_cnt < 65535) m_cnt++;
          end
        end else if (m_words < 4) begin
          wsel = m_words[1:0];
          chk("fill_cache_idx", cache_idx, m_idx);
          chk("fill_stall", stall, 1'b1);
          chk("fill_instr_valid", instr_valid, 1'b0);
          chk("fill_cache_hit", cache_hit, 1'b1);
          chk("fill_mem_req", mem_req, 1'b1);
          chk("fill_mem_addr", mem_addr, {m_tag, m_idx, wsel});
          if (mem_ack) begin
            m_line[m_words] = mem_word({m_tag, m_idx, wsel});
            m_words++;
          end
        end else begin
          chk("wr_cache_hit", cache_hit, 1'b0);
          chk("wr_cache_idx", cache_idx, m_idx);
          chk("wr_cache_tag", cache_tag, m_tag);
          chk("wr_cache_data", cache_data, {m_line[3], m_line[2], m_line[1], m_line[0]});
          chk("wr_stall", stall, 1'b1);
          chk("wr_instr_valid", instr_valid, 1'b0);
          chk("wr_mem_req", mem_req, 1'b0);
          e_v[m_idx] = 1'b1;
          e_t[m_idx] = m_tag;
          for (int j = 0; j < 4; j++) e_w[m_idx][j] = m_line[j];
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    ack_log.delete();
    wr_tag_log.delete();
    wr_idx_log.delete();
    req_cycles  = 0;
    last_wr_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the first cycle with instr_valid, or flags a timeout.
  task automatic wait_hit(input int max, output int at);
    at = -1;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_hit: no instr_valid within %0d cycles", max);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int at;
    for (int i = 0; i < 8; i++) begin
      st_v[i] = 1'b0;
      st_t[i] = '0;
      st_d[i] = '0;
      e_v[i]  = 1'b0;
      e_t[i]  = '0;
    end

    // Reset state with a cold cache.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_miss_count", miss_count, 16'h0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_cache_hit", cache_hit, 1'b1);
    chk("reset_instr_valid", instr_valid, 1'b0);

    // Cold miss on 0x20 with an ack every cycle.
    step();
    clear_logs();
    t0 = cyc;
    fetch_req = 1'b1;
    pc = 32'h20;
    wait_hit(20, at);
    chk("t1_hit_cycle", at - t0, 6);
    chk("t1_write_cycle", last_wr_cyc - t0, 5);
    chk("t1_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t1_ack_addr", (i < ack_log.size()) ? ack_log[i] : 32'hFFFF_FFFF, 32'h20 + i);
    chk("t1_wr_idx", (wr_idx_log.size() > 0) ? wr_idx_log[0] : 3'd7, 3'd0);
    chk("t1_wr_tag", (wr_tag_log.size() > 0) ? wr_tag_log[0] : 27'h7FF_FFFF, 27'd1);
    chk("t1_instr", instr, 32'hC0FE_0020);
    chk("t1_miss_count", miss_count, 16'd1);

    // Sequential hits; a stray ack with no request must be ignored.
    step();
    clear_logs();
    spurious = 1'b1;
    for (int i = 1; i < 4; i++) begin
      pc = 32'h20 + i;
      @(negedge clk);
      chk("t2_instr_valid", instr_valid, 1'b1);
      chk("t2_instr", instr, mem_word(32'h20 + i));
      step();
    end
    chk("t2_instr_last", mem_word(32'h23), 32'hC0FD_0023);
    chk("t2_req_cycles", req_cycles, 0);
    chk("t2_miss_count", miss_count, 16'd1);
    spurious = 1'b0;

    // Conflict miss on index 0, then the original line misses again.
    clear_logs();
    pc = 32'h40;
    wait_hit(40, at);
    chk("t3_wr_tag_a", (wr_tag_log.size() > 0) ? wr_tag_log[0] : 27'h7FF_FFFF, 27'd2);
    step();
    pc = 32'h20;
    wait_hit(40, at);
    chk("t3_writes", wr_tag_log.size(), 2);
    chk("t3_instr", instr, 32'hC0FE_0020);
    chk("t3_miss_count", miss_count, 16'd3);

    // Slow memory: three idle cycles before each ack.
    step();
    clear_logs();
    ack_delay = 3;
    pc = 32'h88;
    wait_hit(60, at);
    ack_delay = 0;
    chk("t4_writes", wr_tag_log.size(), 1);
    chk("t4_req_cycles", req_cycles, 16);
    chk("t4_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_ack_addr", (i < ack_log.size()) ? ack_log[i] : 32'hFFFF_FFFF, 32'h88 + i);
    chk("t4_line", last_wr_data, {32'hC055_008B, 32'hC054_008A, 32'hC057_0089, 32'hC056_0088});
    chk("t4_miss_count", miss_count, 16'd4);

    // pc moves to 0x65 mid-refill of 0x20: line 0 still gets tag 1, then index 1 refills.
    step();
    pc = 32'h40;
    wait_hit(40, at);
    step();
    clear_logs();
    pc = 32'h20;
    step();
    step();
    pc = 32'h65;
    wait_hit(60, at);
    chk("t5_writes", wr_tag_log.size(), 2);
    chk("t5_wr0_idx", (wr_idx_log.size() > 0) ? wr_idx_log[0] : 3'd7, 3'd0);
    chk("t5_wr0_tag", (wr_tag_log.size() > 0) ? wr_tag_log[0] : 27'h7FF_FFFF, 27'd1);
    chk("t5_wr1_idx", (wr_idx_log.size() > 1) ? wr_idx_log[1] : 3'd7, 3'd1);
    chk("t5_wr1_tag", (wr_tag_log.size() > 1) ? wr_tag_log[1] : 27'h7FF_FFFF, 27'd3);
    chk("t5_instr", instr, 32'hC0BB_0065);
    chk("t5_miss_count", miss_count, 16'd7);

    // Reset pulse after the second ack discards the partial line.
    step();
    clear_logs();
    pc = 32'h100;
    step();
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_cache_hit", cache_hit, 1'b1);
    chk("t6_rst_stall", stall, 1'b0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_miss_count", miss_count, 16'd0);
    chk("t6_no_write", wr_tag_log.size(), 0);
    ack_log.delete();
    wait_hit(30, at);
    chk("t6_ack_count", ack_log.size(), 4);
    chk("t6_first_addr", (ack_log.size() > 0) ? ack_log[0] : 32'hFFFF_FFFF, 32'h100);
    chk("t6_writes", wr_tag_log.size(), 1);
    chk("t6_wr_tag", (wr_tag_log.size() > 0) ? wr_tag_log[0] : 27'h7FF_FFFF, 27'd8);
    chk("t6_instr", instr, 32'hC1DE_0100);
    chk("t6_miss_count_after", miss_count, 16'd1);

    step();
    fetch_req = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the 8-line direct-mapped instruction cache storage (27-bit tag, 128-bit line of four instructions). It performs the hit check for the fetch stage and, on a miss, fetches the four-word line from instruction memory over a req/ack handshake. It then writes the line into the cache storage and stalls fetch until the line is resident. It sits between the IF stage, the cache storage array and the instruction memory port.

## Interface
- TAG_W, 27, tag width = pc[31:5]
- IDX_W, 3, line index width = pc[4:2]
- CNT_W, 16, miss counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_req  in  1  IF stage requests instruction at pc
- pc  in  32  instruction word address: [31:5] tag, [4:2] index, [1:0] word-in-line
- instr  out  32  fetched instruction
- instr_valid  out  1  instr valid this cycle
- stall  out  1  fetch must hold pc
- cache_idx  out  3  line address to storage
- cache_valid  in  1  storage valid bit at cache_idx
- cache_tag_rd  in  27  storage tag at cache_idx
- cache_data_rd  in  128  storage line at cache_idx
- cache_hit  out  1  storage write-inhibit; storage writes the line when low
- cache_tag  out  27  tag to write
- cache_data  out  128  line to write
- mem_req  out  1  memory read request
- mem_addr  out  32  memory word address
- mem_rdata  in  32  memory read data, valid when mem_ack
- mem_ack  in  1  one-cycle read completion
- miss_count  out  16  saturating miss counter

## Operation
- States: LOOKUP, FILL, WRITE. Reset enters LOOKUP.
- LOOKUP:
  - cache_idx = pc[4:2]; lookup_hit = cache_valid & (cache_tag_rd == pc[31:5]), combinational.
  - With fetch_req & lookup_hit: instr_valid=1, stall=0, instr = cache_data_rd[32*pc[1:0] +: 32] (word 0 at bits [31:0]).
  - With fetch_req & !lookup_hit: stall=1, instr_valid=0. Latch miss_tag=pc[31:5] and miss_idx=pc[4:2], clear word counter k, increment miss_count (saturate at 16'hFFFF), go to FILL.
  - With fetch_req=0: instr_valid=0, stall=0, no state change.
- FILL:
  - cache_idx = miss_idx, stall=1, instr_valid=0.
  - mem_req=1 (registered), mem_addr = {miss_tag, miss_idx, k}.
  - On mem_ack: buffer[32k +: 32] <= mem_rdata and k increments. After the ack for k=3, mem_req drops and the state goes to WRITE.
  - mem_ack is ignored when mem_req=0.
- WRITE:
  - cache_hit=0 for exactly one cycle; cache_idx=miss_idx, cache_tag=miss_tag, cache_data=buffer; stall=1.
  - Next state is LOOKUP, which re-checks the current pc.
- cache_hit=1 in every state except WRITE. cache_tag and cache_data are don't-care outside WRITE, but are driven from miss_tag and buffer.
- A pc change during FILL (flush) does not abort the refill. The line is written, then LOOKUP evaluates the new pc.
- fetch_req dropping during FILL or WRITE does not abort the refill.

## Timing
- Reset values: state LOOKUP, mem_req=0, mem_addr=0, k=0, buffer=0, miss_tag=0, miss_idx=0, miss_count=0, cache_hit=1.
- instr_valid and stall follow the reset-state combinational rules (stall=0 while rst_n=0).
- Hit: zero-cycle latency, instruction returned in the same cycle as pc.
- Miss is detected in cycle 0. mem_req is high from cycle 1, and an ack may arrive in the same cycle the request is high.
- mem_addr advances the cycle after each ack; mem_req stays high between words.
- Minimum miss penalty with ack every cycle: acks in cycles 1–4, WRITE in cycle 5, hit in cycle 6.
- Reset asserted mid-FILL or mid-WRITE: the partial line is discarded and no storage write occurs (cache_hit=1). mem_req=0 after that edge.
- miss_count at 16'hFFFF stays 16'hFFFF.

## Test plan
- Reset with cold cache, fetch_req=1, pc=32'h0000_0020, memory acks each cycle:
  - mem_addr sequence 0x20, 0x21, 0x22, 0x23.
  - cache_hit=0 in cycle 5 with cache_idx=0, cache_tag=1.
  - instr_valid in cycle 6 with instr = word at 0x20; miss_count=1.
- Sequential pc 0x21–0x23 after that fill -> instr_valid every cycle, no mem_req, miss_count unchanged.
- Conflict miss on pc=0x40 (same index 0, tag 2) -> refill; subsequent pc=0x20 misses again; miss_count=3.
- Memory ack delayed 3 cycles per word -> mem_addr held stable until each ack; WRITE occurs exactly once; no duplicate or missing words in cache_data.
- pc changes from 0x20 to 0x65 during FILL -> line 0 is still written with tag 1, then 0x65 (index 1) misses and refills.
- rst_n low for one cycle after the second ack -> no cache_hit=0 pulse, mem_req=0 next cycle, miss_count=0; re-fetch restarts the fill at word 0.
